// File: rtl/conv2_pkg.sv
// Shared definitions for the conv2 scheduler: partial-sum width, saturation
// limits, FSM state encoding and a counter-width helper.
package conv2_pkg;

  localparam int unsigned PSUM_W = 14;

  localparam logic signed [PSUM_W-1:0] SAT_MAX = PSUM_W'(8191);
  localparam logic signed [PSUM_W-1:0] SAT_MIN = PSUM_W'(-8192);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  // Counter width for n values; a single-value counter still gets one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv2_sched_if.sv
// Window / result handshake bundle between the conv2 scheduler (master) and
// the MAC datapath plus downstream sink (slave).
interface conv2_sched_if #(
  parameter int unsigned OUT_CH = 3,
  parameter int unsigned IN_GRP = 2
);
  import conv2_pkg::*;

  localparam int unsigned WSEL_W = cnt_w(OUT_CH * IN_GRP);
  localparam int unsigned OC_W   = cnt_w(OUT_CH);

  logic                     win_valid;
  logic                     win_ready;
  logic signed [PSUM_W-1:0] psum;
  logic [WSEL_W-1:0]        wsel;
  logic                     calc_en;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [PSUM_W-1:0] out_data;
  logic [OC_W-1:0]          out_ch;

  modport master (
    input  win_valid, psum, out_ready,
    output win_ready, wsel, calc_en, out_valid, out_data, out_ch
  );

  modport slave (
    output win_valid, psum, out_ready,
    input  win_ready, wsel, calc_en, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/conv2_sat_acc.sv
// 14-bit signed saturating adder used for partial-sum accumulation.
module conv2_sat_acc
  import conv2_pkg::*;
(
  input  logic signed [PSUM_W-1:0] a_i,
  input  logic signed [PSUM_W-1:0] b_i,
  output logic signed [PSUM_W-1:0] sum_o
);

  logic [PSUM_W:0] sum_full;

  // One extra bit of headroom; disagreeing top bits mean overflow.
  always_comb begin
    sum_full = {a_i[PSUM_W-1], a_i} + {b_i[PSUM_W-1], b_i};
    sum_o    = sum_full[PSUM_W-1:0];
    if (sum_full[PSUM_W] != sum_full[PSUM_W-1]) begin
      sum_o = sum_full[PSUM_W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/conv2_sched.sv
// conv2 scheduler: sequences OUT_CH x IN_GRP MAC cycles per window position,
// then streams OUT_CH accumulated results, over an FM_W x FM_H feature map.
// Build option: define CONV2_SCHED_RELU_EN to clamp negative results to 0 on
// out_data (accumulators are never modified by the clamp).
module conv2_sched
  import conv2_pkg::*;
#(
  parameter int unsigned OUT_CH = 3,
  parameter int unsigned IN_GRP = 2,
  parameter int unsigned FM_W   = 8,
  parameter int unsigned FM_H   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  conv2_sched_if.master  bus,
  output logic           busy,
  output logic           frame_done
);

  localparam int unsigned OC_W   = cnt_w(OUT_CH);
  localparam int unsigned GRP_W  = cnt_w(IN_GRP);
  localparam int unsigned COL_W  = cnt_w(FM_W);
  localparam int unsigned ROW_W  = cnt_w(FM_H);
  localparam int unsigned WSEL_W = cnt_w(OUT_CH * IN_GRP);
`ifdef CONV2_SCHED_RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  state_e                   state_q, state_d;
  logic [OC_W-1:0]          oc_q, oc_d;
  logic [GRP_W-1:0]         grp_q, grp_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic signed [PSUM_W-1:0] acc_q [OUT_CH];
  logic signed [PSUM_W-1:0] acc_d [OUT_CH];
  logic                     frame_done_q, frame_done_d;

  logic signed [PSUM_W-1:0] acc_cur;
  logic signed [PSUM_W-1:0] acc_base;
  logic signed [PSUM_W-1:0] acc_sum;
  logic                     last_oc, last_grp, last_pos;

  // Group 0 loads psum by adding it to zero, so one adder covers both cases.
  always_comb begin
    acc_cur  = acc_q[oc_q];
    acc_base = (grp_q == '0) ? '0 : acc_cur;
    last_oc  = (oc_q == OC_W'(OUT_CH - 1));
    last_grp = (grp_q == GRP_W'(IN_GRP - 1));
    last_pos = (col_q == COL_W'(FM_W - 1)) && (row_q == ROW_W'(FM_H - 1));
  end

  conv2_sat_acc u_sat_acc (
    .a_i   (acc_base),
    .b_i   (bus.psum),
    .sum_o (acc_sum)
  );

  // State, counters and accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      oc_q         <= '0;
      grp_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < int'(OUT_CH); i++) acc_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      oc_q         <= oc_d;
      grp_q        <= grp_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      acc_q        <= acc_d;
    end
  end

  // Next-state and handshake outputs; everything forced low while in reset.
  always_comb begin
    state_d       = state_q;
    oc_d          = oc_q;
    grp_d         = grp_q;
    col_d         = col_q;
    row_d         = row_q;
    acc_d         = acc_q;
    frame_done_d  = 1'b0;
    bus.win_ready = 1'b0;
    bus.calc_en   = 1'b0;
    bus.wsel      = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_ch    = '0;
    busy          = (state_q != IDLE);
    frame_done    = frame_done_q;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = MAC;
      end
      MAC: begin
        bus.wsel = WSEL_W'(grp_q * OUT_CH + oc_q);
        if (bus.win_valid) begin
          bus.calc_en  = 1'b1;
          acc_d[oc_q]  = acc_sum;
          if (last_oc) begin
            bus.win_ready = 1'b1;
            oc_d          = '0;
            if (last_grp) begin
              grp_d   = '0;
              state_d = OUT;
            end else begin
              grp_d = grp_q + GRP_W'(1);
            end
          end else begin
            oc_d = oc_q + OC_W'(1);
          end
        end
      end
      OUT: begin
        bus.out_valid = 1'b1;
        bus.out_ch    = oc_q;
        bus.out_data  = (Relu && acc_cur[PSUM_W-1]) ? '0 : acc_cur;
        if (bus.out_ready) begin
          if (last_oc) begin
            oc_d = '0;
            if (last_pos) begin
              col_d        = '0;
              row_d        = '0;
              state_d      = IDLE;
              frame_done_d = 1'b1;
            end else begin
              state_d = MAC;
              if (col_q == COL_W'(FM_W - 1)) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
              end else begin
                col_d = col_q + COL_W'(1);
              end
            end
          end else begin
            oc_d = oc_q + OC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      bus.win_ready = 1'b0;
      bus.calc_en   = 1'b0;
      bus.wsel      = '0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_ch    = '0;
      busy          = 1'b0;
      frame_done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_conv2_sched.sv
// Directed self-checking bench for conv2_sched with default parameters.
module tb_conv2_sched;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  conv2_sched_if #(.OUT_CH(3), .IN_GRP(2)) bus ();

  conv2_sched #(
    .OUT_CH (3),
    .IN_GRP (2),
    .FM_W   (8),
    .FM_H   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

`ifdef CONV2_SCHED_RELU_EN
  localparam int NegSat = 0;
`else
  localparam int NegSat = -8192;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One MAC cycle: k is the expected weight-bank index.
  task automatic mac_step(input int k, input int ps);
    bus.win_valid = 1'b1;
    bus.psum      = 14'(ps);
    #1;
    chk("mac_calc_en", 32'(bus.calc_en), 1);
    chk("mac_wsel", 32'(bus.wsel), k);
    chk("mac_win_ready", 32'(bus.win_ready), (k % 3 == 2) ? 1 : 0);
    chk("mac_out_valid", 32'(bus.out_valid), 0);
    step();
  endtask

  // One accepted result beat.
  task automatic beat(input int c, input int d);
    bus.out_ready = 1'b1;
    #1;
    chk("beat_valid", 32'(bus.out_valid), 1);
    chk("beat_ch", 32'(bus.out_ch), c);
    chk("beat_data", 32'(bus.out_data), d);
    chk("beat_calc_en", 32'(bus.calc_en), 0);
    step();
  endtask

  int cycles;
  int beats;

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    bus.win_valid = 1'b0;
    bus.psum      = '0;
    bus.out_ready = 1'b0;
    step();
    step();

    // Reset state.
    chk("rst_busy", 32'(busy), 0);
    chk("rst_calc_en", 32'(bus.calc_en), 0);
    chk("rst_win_ready", 32'(bus.win_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_ch", 32'(bus.out_ch), 0);
    chk("rst_wsel", 32'(bus.wsel), 0);
    chk("rst_frame_done", 32'(frame_done), 0);

    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);

    // Frame 1: psum=10 throughout, no stalls.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) mac_step(k, 10);
    for (int c = 0; c < 3; c++) beat(c, 20);

    // Remaining 63 positions; a stray start mid-frame must change nothing.
    cycles = 0;
    beats  = 0;
    while (!frame_done && cycles < 2000) begin
      start = (cycles == 3);
      #1;
      chk("run_busy", 32'(busy), 1);
      if (bus.out_valid && bus.out_ready) begin
        beats++;
        chk("run_data", 32'(bus.out_data), 20);
      end
      step();
      cycles++;
    end
    start = 1'b0;
    chk("done_seen", 32'(frame_done), 1);
    chk("done_cycles", cycles, 567);
    chk("done_beats", beats, 189);
    chk("done_busy", 32'(busy), 0);
    step();
    chk("done_pulse_len", 32'(frame_done), 0);
    chk("done_idle_calc", 32'(bus.calc_en), 0);

    // Frame 2: reset while position 10 is in OUT.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 96; i++) step();
    chk("p10_out_valid", 32'(bus.out_valid), 1);
    chk("p10_out_ch", 32'(bus.out_ch), 0);
    chk("p10_out_data", 32'(bus.out_data), 20);
    rst = 1'b1;
    #1;
    chk("in_rst_out_valid", 32'(bus.out_valid), 0);
    chk("in_rst_busy", 32'(busy), 0);
    chk("in_rst_out_data", 32'(bus.out_data), 0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_out_valid", 32'(bus.out_valid), 0);
    step();

    // Frame 3 position 0: varied psums with a 5-cycle window stall.
    start = 1'b1;
    step();
    start = 1'b0;
    mac_step(0, 100);
    mac_step(1, 200);
    bus.win_valid = 1'b0;
    bus.psum      = 14'(999);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_calc_en", 32'(bus.calc_en), 0);
      chk("stall_wsel", 32'(bus.wsel), 2);
      chk("stall_win_ready", 32'(bus.win_ready), 0);
      step();
    end
    mac_step(2, 300);
    mac_step(3, -50);
    mac_step(4, 1000);
    mac_step(5, 7);
    beat(0, 50);

    // Hold the oc=1 beat for 4 cycles.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_ch", 32'(bus.out_ch), 1);
      chk("hold_data", 32'(bus.out_data), 1200);
      chk("hold_calc_en", 32'(bus.calc_en), 0);
      step();
    end
    beat(1, 1200);
    beat(2, 307);

    // Position 1: saturation in both directions, group-0 load discards old sums.
    mac_step(0, 8000);
    mac_step(1, 8000);
    mac_step(2, -8000);
    mac_step(3, 8000);
    mac_step(4, 100);
    mac_step(5, -8000);
    beat(0, 8191);
    beat(1, 8100);
    beat(2, NegSat);
    #1;
    chk("pos2_wsel", 32'(bus.wsel), 0);
    chk("pos2_calc_en", 32'(bus.calc_en), 1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("final_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv2_sched.md
CONV2_SCHED -- requirements
Module: conv2_sched

Interface
- REQ-001 SHALL have parameter OUT_CH, default 3: number of conv2 output channels sequenced per window position.
- REQ-002 SHALL have parameter IN_GRP, default 2: number of 3-channel input groups accumulated per position.
- REQ-003 SHALL have parameter FM_W, default 8: output feature-map width, in positions.
- REQ-004 SHALL have parameter FM_H, default 8: output feature-map height, in positions.
- REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
- REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-007 SHALL have port start, input, 1 bit: single-cycle frame start request.
- REQ-008 SHALL have port win_valid, input, 1 bit: upstream window for the current group is present and stable.
- REQ-009 SHALL have port win_ready, output, 1 bit: current window is consumed this cycle.
- REQ-010 SHALL have port psum, input, 14 bits signed: combinational partial sum from the 5x5x3 MAC datapath.
- REQ-011 SHALL have port wsel, output, clog2(OUT_CH*IN_GRP) bits: weight-bank select for the datapath.
- REQ-012 SHALL have port calc_en, output, 1 bit: psum is sampled this cycle.
- REQ-013 SHALL have port out_valid, output, 1 bit: result beat is valid.
- REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts the result beat.
- REQ-015 SHALL have port out_data, output, 14 bits signed: accumulated result.
- REQ-016 SHALL have port out_ch, output, clog2(OUT_CH) bits: output-channel index of out_data.
- REQ-017 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
- REQ-018 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last beat of a frame.

Function
- REQ-019 SHALL implement the states IDLE, MAC and OUT.
- REQ-020 SHALL move IDLE->MAC on start; start SHALL be ignored in any other state.
- REQ-021 MAC: each cycle with win_valid=1, SHALL drive calc_en=1 and wsel=grp*OUT_CH+oc, then accumulate psum into acc[oc].
  - grp=0: acc[oc] is loaded with psum.
  - Otherwise: acc[oc] <= acc[oc]+psum.
- REQ-022 MAC with win_valid=0: SHALL hold all counters and accumulators and drive calc_en=0.
- REQ-023 win_ready SHALL equal (state==MAC) && win_valid && (oc==OUT_CH-1), so each window is consumed exactly once after OUT_CH MAC cycles.
- REQ-024 After the OUT_CH-1 MAC cycle, the block SHALL set oc=0 and then:
  - If grp==IN_GRP-1: set grp=0 and go to OUT.
  - Otherwise: increment grp and stay in MAC.
- REQ-025 OUT: SHALL drive out_valid=1, out_ch=oc and out_data=acc[oc]; oc SHALL advance only when out_ready=1, and out_data SHALL be held stable while out_ready=0.
- REQ-026 After the beat with oc==OUT_CH-1 is accepted, the block SHALL take one of two paths:
  - Last position (col==FM_W-1, row==FM_H-1): go to IDLE and pulse frame_done for one cycle.
  - Otherwise: advance col, wrapping to 0 and incrementing row, then return to MAC.
- REQ-027 Accumulation SHALL be saturating at 14 bits: results above 8191 become 8191, and results below -8192 become -8192.
- REQ-028 Minimum cycles per position SHALL be IN_GRP*OUT_CH + OUT_CH (no stalls).
- REQ-029 OUT_CH=1 and IN_GRP=1 SHALL be legal and SHALL follow the same rules.

Reset
- REQ-030 While rst=1, the block SHALL enter IDLE and clear oc, grp, col, row and all acc entries to 0, at any state including mid-frame.
- REQ-031 During reset, the outputs SHALL be win_ready=0, calc_en=0, out_valid=0, out_data=0, out_ch=0, wsel=0, busy=0 and frame_done=0.

Configuration
- REQ-032 With CONV2_SCHED_RELU_EN defined, out_data SHALL be 0 whenever acc[oc] is negative, and acc[oc] otherwise.
- REQ-033 Without CONV2_SCHED_RELU_EN, out_data SHALL be the raw signed acc[oc]; accumulator contents SHALL be unaffected in both builds.

Structure
- REQ-034 The shared package conv2_pkg SHALL hold:
  - PSUM_W=14;
  - SAT_MAX=8191 and SAT_MIN=-8192;
  - the state enum {IDLE, MAC, OUT}.
- REQ-035 The saturating add SHALL be a sub-module conv2_sat_acc (two 14-bit signed inputs, one 14-bit saturated output), instantiated once.

Verification
- REQ-036 Defaults, start, win_valid held high, psum=10 every cycle -> wsel sequence 0,1,2,3,4,5; per position three beats, each out_data=20, out_ch=0,1,2; frame_done after 64 positions (192 beats).
- REQ-037 psum=8000 for both groups -> out_data=8191; psum=-8000 for both groups -> out_data=-8192 (0 with CONV2_SCHED_RELU_EN).
- REQ-038 win_valid low for 5 cycles mid-group -> calc_en=0 and wsel frozen for those 5 cycles; results match the no-stall run.
- REQ-039 out_ready low for 4 cycles on beat oc=1 -> out_valid, out_ch=1 and out_data stable; no MAC activity until the oc=2 beat is accepted.
- REQ-040 rst pulse during the OUT state of position 10 -> next cycle state IDLE, busy=0 and out_valid=0; a new start begins again at position 0 with wsel=0.
- REQ-041 start asserted while busy -> ignored; frame length is unchanged.
